// File: rtl/sprite_pkg.sv
// Shared geometry, enums and address-width derivation for the sprite fetch path.
package sprite_pkg;
  localparam int SPR_W   = 16;  // sprite width, power of 2
  localparam int SPR_H   = 16;  // sprite height, power of 2
  localparam int FRAMES  = 2;   // animation frames per direction, power of 2
  localparam int ADDR_W  = $clog2(4 * FRAMES * SPR_W * SPR_H);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic {IDLE, WALK} anim_state_t;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// Walk-animation sequencer: latches direction and steps the animation frame,
// touching state only on frame_start so everything is stable through scanout.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8  // frame_start pulses per animation step, 1..255
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               moving,
  input  dir_t               dir,
  output logic [FRAME_W-1:0] frame,
  output dir_t               dir_q
);

  anim_state_t        state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  dir_t               dir_hold_q, dir_hold_d;

  // Next state: nothing moves unless this is a frame_start cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    dir_hold_d = dir_hold_q;
    if (frame_start) begin
      dir_hold_d = dir;
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          frame_d = '0;
          if (moving) state_d = WALK;
        end
        WALK: begin
          if (!moving) begin
            state_d = IDLE;
            cnt_d   = '0;
            frame_d = '0;
          end else if (cnt_q == 8'(ANIM_DIV - 1)) begin
            cnt_d   = '0;
            frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      dir_hold_q <= DIR_DOWN;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      dir_hold_q <= dir_hold_d;
    end
  end

  assign frame = frame_q;
  assign dir_q = dir_hold_q;

endmodule

// File: rtl/sprite_index_fetch.sv
// Per-pixel sprite fetch: hit test, ROM address, ROM wait, palette index.
// Fixed 3-cycle latency from DrawX/DrawY to pix_index/pix_on, never stalls.
module sprite_index_fetch
  import sprite_pkg::*;
#(
  parameter int         ANIM_DIV   = 8,
  parameter logic [3:0] TRANSP_IDX = 4'd0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic [1:0]        dir,
  input  logic              moving,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_on
);

  logic [FRAME_W-1:0] frame;
  dir_t               dir_q;

  sprite_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .moving      (moving),
    .dir         (dir_t'(dir)),
    .frame       (frame),
    .dir_q       (dir_q)
  );

  // Stage 0: offsets wrap mod 1024, so the >= compares reject wrapped hits
  // and a sprite hanging off the right/bottom edge is simply clipped.
  logic [9:0]        relx, rely;
  logic              hit;
  logic [ADDR_W-1:0] addr_d;

  assign relx = DrawX - spr_x;
  assign rely = DrawY - spr_y;
  assign hit  = (DrawX >= spr_x) && (relx < 10'(SPR_W)) &&
                (DrawY >= spr_y) && (rely < 10'(SPR_H));
  assign addr_d = ADDR_W'(((32'(dir_q) * 32'(FRAMES) + 32'(frame)) * 32'(SPR_H)
                           + 32'(rely)) * 32'(SPR_W) + 32'(relx));

  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        hit_pipe_q;   // [0] aligned with rom_addr, [1] with rom_q
  logic [3:0]        pix_index_q;
  logic              pix_on_q;

  // Pipeline: address on a hit (held on a miss), hit flag follows the ROM read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q  <= '0;
      hit_pipe_q  <= '0;
      pix_index_q <= '0;
      pix_on_q    <= 1'b0;
    end else begin
      if (hit) rom_addr_q <= addr_d;
      hit_pipe_q  <= {hit_pipe_q[0], hit};
      pix_index_q <= hit_pipe_q[1] ? rom_q : TRANSP_IDX;
      pix_on_q    <= hit_pipe_q[1] && (rom_q != TRANSP_IDX);
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_index = pix_index_q;
  assign pix_on    = pix_on_q;

endmodule
